// File: rtl/exe_mult_stage.sv
// MiniMIPS32 execute stage: ALU/shift/HI-LO moves, address generation, an iterative
// 32-cycle signed multiplier that stalls the front end, and the EXE/MEM pipeline register.
module exe_mult_stage (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic [2:0]  exe_alutype_i,
    input  logic [7:0]  exe_aluop_i,
    input  logic [4:0]  exe_wa_i,
    input  logic        exe_wreg_i,
    input  logic        exe_whilo_i,
    input  logic        exe_mreg_i,
    input  logic [31:0] exe_src1_i,
    input  logic [31:0] exe_src2_i,
    input  logic [31:0] exe_din_i,
    output logic        stallreq_o,
    output logic [7:0]  mem_aluop_o,
    output logic [4:0]  mem_wa_o,
    output logic        mem_wreg_o,
    output logic        mem_mreg_o,
    output logic [31:0] mem_wd_o,
    output logic [31:0] mem_din_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] TypeArith = 3'd1;
    localparam logic [2:0] TypeLogic = 3'd2;
    localparam logic [2:0] TypeMove  = 3'd3;
    localparam logic [2:0] TypeShift = 3'd4;

    localparam logic [7:0] OpAdd   = 8'h18;
    localparam logic [7:0] OpAddiu = 8'h19;
    localparam logic [7:0] OpLb    = 8'h90;
    localparam logic [7:0] OpLw    = 8'h92;
    localparam logic [7:0] OpSb    = 8'h98;
    localparam logic [7:0] OpSw    = 8'h9A;
    localparam logic [7:0] OpSubu  = 8'h1B;
    localparam logic [7:0] OpSlt   = 8'h26;
    localparam logic [7:0] OpSltiu = 8'h27;
    localparam logic [7:0] OpAnd   = 8'h1C;
    localparam logic [7:0] OpOri   = 8'h1D;
    localparam logic [7:0] OpLui   = 8'h05;
    localparam logic [7:0] OpSll   = 8'h11;
    localparam logic [7:0] OpMfhi  = 8'h0C;
    localparam logic [7:0] OpMflo  = 8'h0D;
    localparam logic [7:0] OpMult  = 8'h14;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mult_state_e;

    mult_state_e state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic        sign_q, sign_d;
    logic [31:0] hi_q, lo_q;
    logic        hilo_we;
    logic        is_mult;
    logic [31:0] abs1, abs2;
    logic [63:0] product;
    logic [31:0] exe_wd;

    assign is_mult = (exe_aluop_i == OpMult);
    assign abs1    = exe_src1_i[31] ? (~exe_src1_i + 32'd1) : exe_src1_i;
    assign abs2    = exe_src2_i[31] ? (~exe_src2_i + 32'd1) : exe_src2_i;
    assign product = sign_q ? (~acc_q + 64'd1) : acc_q;

    // Gated by reset so the front end is released immediately when reset aborts a multiply.
    assign stallreq_o = cpu_rst_n && is_mult && (state_q != StDone);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        hilo_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (is_mult) begin
                    mcand_d  = {32'd0, abs1};
                    mplier_d = abs2;
                    acc_d    = 64'd0;
                    sign_d   = exe_src1_i[31] ^ exe_src2_i[31];
                    cnt_d    = 5'd0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = StDone;
            end
            StDone: begin
                hilo_we = exe_whilo_i;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (hilo_we) begin
            hi_q <= product[63:32];
            lo_q <= product[31:0];
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

    // Operation class picks the result group; MULT and unknown codes fall through to 0.
    always_comb begin
        exe_wd = 32'd0;
        case (exe_alutype_i)
            TypeArith: begin
                case (exe_aluop_i)
                    OpAdd, OpAddiu, OpLb, OpLw, OpSb, OpSw: exe_wd = exe_src1_i + exe_src2_i;
                    OpSubu:  exe_wd = exe_src1_i - exe_src2_i;
                    OpSlt:   exe_wd = {31'd0, $signed(exe_src1_i) < $signed(exe_src2_i)};
                    OpSltiu: exe_wd = {31'd0, exe_src1_i < exe_src2_i};
                    default: exe_wd = 32'd0;
                endcase
            end
            TypeLogic: begin
                case (exe_aluop_i)
                    OpAnd:        exe_wd = exe_src1_i & exe_src2_i;
                    OpOri, OpLui: exe_wd = exe_src1_i | exe_src2_i;
                    default:      exe_wd = 32'd0;
                endcase
            end
            TypeMove: begin
                case (exe_aluop_i)
                    OpMfhi:  exe_wd = hi_q;
                    OpMflo:  exe_wd = lo_q;
                    default: exe_wd = 32'd0;
                endcase
            end
            TypeShift: begin
                if (exe_aluop_i == OpSll) exe_wd = exe_src2_i << exe_src1_i[4:0];
            end
            default: exe_wd = 32'd0;
        endcase
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            mem_aluop_o <= 8'd0;
            mem_wa_o    <= 5'd0;
            mem_wreg_o  <= 1'b0;
            mem_mreg_o  <= 1'b0;
            mem_wd_o    <= 32'd0;
            mem_din_o   <= 32'd0;
        end else if (!stallreq_o) begin
            mem_aluop_o <= exe_aluop_i;
            mem_wa_o    <= exe_wa_i;
            mem_wreg_o  <= exe_wreg_i & ~is_mult;
            mem_mreg_o  <= exe_mreg_i;
            mem_wd_o    <= is_mult ? 32'd0 : exe_wd;
            mem_din_o   <= exe_din_i;
        end
    end

endmodule

// File: tb/tb_exe_mult_stage.sv
// Scoreboard bench for exe_mult_stage: expected EXE/MEM contents queued at issue, popped
// when the stage captures them; HI/LO tracked by a reference model.
module tb_exe_mult_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  alutype = '0;
    logic [7:0]  aluop = '0;
    logic [4:0]  wa = '0;
    logic        wreg = 1'b0, whilo = 1'b0, mreg = 1'b0;
    logic [31:0] src1 = '0, src2 = '0, din = '0;
    logic        stallreq;
    logic [7:0]  mem_aluop;
    logic [4:0]  mem_wa;
    logic        mem_wreg, mem_mreg;
    logic [31:0] mem_wd, mem_din, hi, lo;

    exe_mult_stage dut (
        .cpu_clk_50M   (clk),
        .cpu_rst_n     (rst_n),
        .exe_alutype_i (alutype),
        .exe_aluop_i   (aluop),
        .exe_wa_i      (wa),
        .exe_wreg_i    (wreg),
        .exe_whilo_i   (whilo),
        .exe_mreg_i    (mreg),
        .exe_src1_i    (src1),
        .exe_src2_i    (src2),
        .exe_din_i     (din),
        .stallreq_o    (stallreq),
        .mem_aluop_o   (mem_aluop),
        .mem_wa_o      (mem_wa),
        .mem_wreg_o    (mem_wreg),
        .mem_mreg_o    (mem_mreg),
        .mem_wd_o      (mem_wd),
        .mem_din_o     (mem_din),
        .hi_o          (hi),
        .lo_o          (lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [4:0]  wa;
        logic        wreg;
        logic        mreg;
        logic [31:0] wd;
        logic [31:0] din;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] class_of(input logic [7:0] op);
        case (op)
            8'h1C, 8'h1D, 8'h05: return 3'd2;
            8'h0C, 8'h0D:        return 3'd3;
            8'h11:               return 3'd4;
            default:             return 3'd1;
        endcase
    endfunction

    function automatic logic [31:0] model_wd(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            8'h18, 8'h19, 8'h90, 8'h92, 8'h98, 8'h9A: return a + b;
            8'h1B: return a - b;
            8'h26: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            8'h27: return (a < b) ? 32'd1 : 32'd0;
            8'h1C: return a & b;
            8'h1D, 8'h05: return a | b;
            8'h11: return b << a[4:0];
            8'h0C: return m_hi;
            8'h0D: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic pop_check();
        exp_t e;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("mem_aluop", 64'(mem_aluop), 64'(e.aluop));
            check("mem_wa", 64'(mem_wa), 64'(e.wa));
            check("mem_wreg", 64'(mem_wreg), 64'(e.wreg));
            check("mem_mreg", 64'(mem_mreg), 64'(e.mreg));
            check("mem_wd", 64'(mem_wd), 64'(e.wd));
            check("mem_din", 64'(mem_din), 64'(e.din));
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that captures the result.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic [4:0] w, input logic we,
                         input logic mr);
        exp_t e;
        logic signed [63:0] p;
        int stall_cycles;
        alutype = class_of(op);
        aluop   = op;
        src1    = a;
        src2    = b;
        din     = d;
        wa      = w;
        wreg    = we;
        mreg    = mr;
        whilo   = (op == 8'h14);
        e.aluop = op;
        e.wa    = w;
        e.wreg  = we && (op != 8'h14);
        e.mreg  = mr;
        e.wd    = model_wd(op, a, b);
        e.din   = d;
        sb.push_back(e);
        #1;
        if (op != 8'h14) begin
            check("stall_low", 64'(stallreq), 64'd0);
            @(posedge clk);
            #1;
            pop_check();
        end else begin
            stall_cycles = 0;
            while (stallreq && stall_cycles < 100) begin
                stall_cycles++;
                @(posedge clk);
                #1;
            end
            check("stall_len", 64'(stall_cycles), 64'd33);
            @(posedge clk);
            #1;
            pop_check();
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            m_hi = p[63:32];
            m_lo = p[31:0];
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("rst_stall", 64'(stallreq), 64'd0);
        check("rst_mem_wd", 64'(mem_wd), 64'd0);
        check("rst_mem_wreg", 64'(mem_wreg), 64'd0);
        check("rst_mem_wa", 64'(mem_wa), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(8'h19, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd8, 1'b1, 1'b0);   // addiu overflow wrap
        issue(8'h26, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd9, 1'b1, 1'b0);   // slt -> 1
        issue(8'h27, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd10, 1'b1, 1'b0);  // sltiu -> 0
        issue(8'h11, 32'd4, 32'h0000_000F, 32'd0, 5'd11, 1'b1, 1'b0);  // sll -> 0xF0
        issue(8'h1B, 32'd10, 32'd13, 32'd0, 5'd12, 1'b1, 1'b0);
        issue(8'h1C, 32'hF0F0_FFFF, 32'h0FF0_00F0, 32'd0, 5'd13, 1'b1, 1'b0);
        issue(8'h1D, 32'h1200_0000, 32'h0000_0034, 32'd0, 5'd14, 1'b1, 1'b0);
        issue(8'h05, 32'd0, 32'hABCD_0000, 32'd0, 5'd15, 1'b1, 1'b0);
        issue(8'h90, 32'h2000, 32'hFFFF_FFFC, 32'd0, 5'd16, 1'b1, 1'b1);  // lb address
        issue(8'h7F, 32'd5, 32'd6, 32'h55, 5'd17, 1'b1, 1'b0);          // unknown code

        issue(8'h14, 32'hFFFF_FFFD, 32'd5, 32'd0, 5'd0, 1'b0, 1'b0);    // -3 * 5
        check("hi_m3x5", 64'(hi), 64'hFFFF_FFFF);
        check("lo_m3x5", 64'(lo), 64'hFFFF_FFF1);
        issue(8'h0D, 32'd0, 32'd0, 32'd0, 5'd2, 1'b1, 1'b0);            // mflo
        issue(8'h0C, 32'd0, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0);            // mfhi

        issue(8'h14, 32'h8000_0000, 32'h8000_0000, 32'd0, 5'd0, 1'b0, 1'b0);
        check("hi_min2", 64'(hi), 64'h4000_0000);
        check("lo_min2", 64'(lo), 64'd0);
        issue(8'h14, 32'd7, 32'd6, 32'd0, 5'd0, 1'b0, 1'b0);            // back-to-back
        check("lo_7x6", 64'(lo), 64'd42);
        issue(8'h0D, 32'd0, 32'd0, 32'd0, 5'd4, 1'b1, 1'b0);

        issue(8'h9A, 32'h1000, 32'h4, 32'hDEAD_BEEF, 5'd5, 1'b0, 1'b0); // sw

        // Reset in the middle of a multiply, at BUSY count 10.
        alutype = 3'd1;
        aluop   = 8'h14;
        src1    = 32'd9;
        src2    = 32'd9;
        whilo   = 1'b1;
        wreg    = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("busy_stall", 64'(stallreq), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_stall", 64'(stallreq), 64'd0);
        check("abort_mem_wd", 64'(mem_wd), 64'd0);
        check("abort_mem_din", 64'(mem_din), 64'd0);
        check("abort_mem_aluop", 64'(mem_aluop), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        sb.delete();
        m_hi  = '0;
        m_lo  = '0;
        aluop = 8'h00;
        alutype = 3'd0;
        whilo = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(8'h18, 32'd2, 32'd3, 32'd0, 5'd6, 1'b1, 1'b0);            // add after reset
        check("add_wd", 64'(mem_wd), 64'd5);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
